slot_scheduler: RTL and testbench

//  Sequences the mapped polar frame onto the spinning LED arm. Measures revolution period

---
 rtl/slot_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_slot_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/slot_scheduler.sv
// Revolution-locked column scheduler for the spinning LED arm: measures the hall period,
// splits each turn into equal angular slots and streams one double-buffered frame column per slot.
module slot_scheduler #(
  parameter int NO_ARM_LED         = 32,
  parameter int NO_DELTA_INTERVALS = 16,
  parameter int RGB_SIZE           = 8,
  parameter int PERIOD_W           = 24,
  parameter int MIN_PERIOD         = 256,
  localparam int COL_W   = NO_ARM_LED * RGB_SIZE,
  localparam int OUT_DIM = NO_DELTA_INTERVALS * COL_W,
  localparam int SLOT_W  = $clog2(NO_DELTA_INTERVALS)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               hall,
  input  logic [OUT_DIM-1:0] frame_in,
  input  logic               frame_valid,
  output logic               frame_ack,
  output logic [COL_W-1:0]   led_data,
  output logic               led_valid,
  input  logic               led_ready,
  output logic [SLOT_W-1:0]  slot_idx,
  output logic               locked,
  output logic               underrun,
  output logic               overspeed
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, RUN} state_t;

  state_t                state_q, state_d;
  logic                  hall_q;
  logic [PERIOD_W-1:0]   rev_cnt_q, rev_cnt_d;
  logic [PERIOD_W-1:0]   slot_len_q, slot_len_d;
  logic [PERIOD_W-1:0]   slot_cnt_q, slot_cnt_d;
  logic [SLOT_W-1:0]     slot_idx_q, slot_idx_d;
  logic                  done_q, done_d;
  logic [COL_W-1:0]      led_data_q, led_data_d;
  logic                  led_valid_q, led_valid_d;
  logic [OUT_DIM-1:0]    shadow_q, shadow_d;
  logic [OUT_DIM-1:0]    active_q, active_d;
  logic                  shadow_full_q, shadow_full_d;
  logic                  frame_ack_q, frame_ack_d;
  logic                  underrun_q, underrun_d;
  logic                  overspeed_q, overspeed_d;

  logic                  rise, rev_sat, period_ok, promote, slot_end, last_slot;
  logic [PERIOD_W:0]     period_w;
  logic [PERIOD_W-1:0]   new_len;
  logic [SLOT_W-1:0]     next_slot;
  logic [OUT_DIM-1:0]    active_nx;

  always_comb begin
    rise      = hall & ~hall_q;
    rev_sat   = &rev_cnt_q;
    period_w  = {1'b0, rev_cnt_q} + (PERIOD_W+1)'(1);
    period_ok = period_w >= (PERIOD_W+1)'(MIN_PERIOD);
    new_len   = PERIOD_W'(period_w >> SLOT_W);
    // A pending frame goes live at once when not scheduling, otherwise only on angle 0
    promote   = shadow_full_q & ((state_q != RUN) | rise);
    active_nx = promote ? shadow_q : active_q;
    slot_end  = slot_cnt_q == (slot_len_q - PERIOD_W'(1));
    last_slot = slot_idx_q == SLOT_W'(NO_DELTA_INTERVALS - 1);
    next_slot = slot_idx_q + SLOT_W'(1);

    state_d       = state_q;
    rev_cnt_d     = rev_sat ? rev_cnt_q : rev_cnt_q + PERIOD_W'(1);
    slot_len_d    = slot_len_q;
    slot_cnt_d    = slot_cnt_q;
    slot_idx_d    = slot_idx_q;
    done_d        = done_q;
    led_data_d    = led_data_q;
    led_valid_d   = led_valid_q & ~led_ready;
    shadow_d      = shadow_q;
    active_d      = active_nx;
    shadow_full_d = shadow_full_q & ~promote;
    frame_ack_d   = 1'b0;
    underrun_d    = underrun_q;
    overspeed_d   = overspeed_q;

    if (rise) rev_cnt_d = '0;

    // Skip the cycle after an ack: the source still shows the frame it just handed over
    if (frame_valid & ~frame_ack_q & (~shadow_full_q | promote)) begin
      shadow_d      = frame_in;
      shadow_full_d = 1'b1;
      frame_ack_d   = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (rise) state_d = ACQUIRE;
      end
      ACQUIRE: begin
        if (rise) begin
          if (period_ok) begin
            state_d     = RUN;
            slot_len_d  = new_len;
            slot_idx_d  = '0;
            slot_cnt_d  = '0;
            done_d      = 1'b0;
            led_data_d  = active_nx[0 +: COL_W];
            led_valid_d = 1'b1;
          end else begin
            overspeed_d = 1'b1;
          end
        end else if (rev_sat) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (rise) begin
          if (led_valid_q & ~led_ready) underrun_d = 1'b1;
          if (period_ok) begin
            slot_len_d  = new_len;
            slot_idx_d  = '0;
            slot_cnt_d  = '0;
            done_d      = 1'b0;
            led_data_d  = active_nx[0 +: COL_W];
            led_valid_d = 1'b1;
          end else begin
            overspeed_d = 1'b1;
            state_d     = ACQUIRE;
            led_valid_d = 1'b0;
            slot_idx_d  = '0;
          end
        end else if (rev_sat) begin
          state_d     = IDLE;
          led_valid_d = 1'b0;
          slot_idx_d  = '0;
        end else if (!done_q) begin
          if (slot_end) begin
            if (led_valid_q & ~led_ready) underrun_d = 1'b1;
            slot_cnt_d = '0;
            if (last_slot) begin
              done_d      = 1'b1;
              led_valid_d = 1'b0;
            end else begin
              slot_idx_d  = next_slot;
              led_data_d  = active_nx[int'(next_slot) * COL_W +: COL_W];
              led_valid_d = 1'b1;
            end
          end else begin
            slot_cnt_d = slot_cnt_q + PERIOD_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= IDLE;
      hall_q        <= 1'b0;
      rev_cnt_q     <= '0;
      slot_len_q    <= '0;
      slot_cnt_q    <= '0;
      slot_idx_q    <= '0;
      done_q        <= 1'b0;
      led_data_q    <= '0;
      led_valid_q   <= 1'b0;
      shadow_q      <= '0;
      active_q      <= '0;
      shadow_full_q <= 1'b0;
      frame_ack_q   <= 1'b0;
      underrun_q    <= 1'b0;
      overspeed_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hall_q        <= hall;
      rev_cnt_q     <= rev_cnt_d;
      slot_len_q    <= slot_len_d;
      slot_cnt_q    <= slot_cnt_d;
      slot_idx_q    <= slot_idx_d;
      done_q        <= done_d;
      led_data_q    <= led_data_d;
      led_valid_q   <= led_valid_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      shadow_full_q <= shadow_full_d;
      frame_ack_q   <= frame_ack_d;
      underrun_q    <= underrun_d;
      overspeed_q   <= overspeed_d;
    end
  end

  assign frame_ack = frame_ack_q;
  assign led_data  = led_data_q;
  assign led_valid = led_valid_q;
  assign slot_idx  = slot_idx_q;
  assign locked    = state_q == RUN;
  assign underrun  = underrun_q;
  assign overspeed = overspeed_q;

endmodule

// File: tb/tb_slot_scheduler.sv
// Directed bench for slot_scheduler: revolution/slot timing table plus hand-written
// sequences for stalls, frame double-buffering, overspeed, timeout and mid-run reset.
module tb_slot_scheduler;
  localparam int NL = 32, ND = 16, RS = 8, PW = 12, MP = 256;
  localparam int COL_W = NL * RS, OUT_DIM = ND * COL_W, SW = $clog2(ND);

  logic               clock = 1'b0, resetn = 1'b0, hall = 1'b0;
  logic               frame_valid = 1'b0, led_ready = 1'b1;
  logic [OUT_DIM-1:0] frame_in = '0;
  logic               frame_ack, led_valid, locked, underrun, overspeed;
  logic [COL_W-1:0]   led_data;
  logic [SW-1:0]      slot_idx;

  slot_scheduler #(.NO_ARM_LED(NL), .NO_DELTA_INTERVALS(ND), .RGB_SIZE(RS),
                   .PERIOD_W(PW), .MIN_PERIOD(MP)) dut (
    .clock(clock), .resetn(resetn), .hall(hall), .frame_in(frame_in),
    .frame_valid(frame_valid), .frame_ack(frame_ack), .led_data(led_data),
    .led_valid(led_valid), .led_ready(led_ready), .slot_idx(slot_idx),
    .locked(locked), .underrun(underrun), .overspeed(overspeed));

  always #5 clock = ~clock;

  int checks = 0, errors = 0, ack_cnt = 0, ack_base = 0;
  bit mon_en = 1'b0;
  logic [OUT_DIM-1:0] exp_frame = '0;
  logic [OUT_DIM-1:0] fa, fb;

  typedef struct { int gap; bit rise; int slot; bit vld; bit lck; } vec_t;
  vec_t tbl[16];

  function automatic logic [OUT_DIM-1:0] make_frame(input logic [7:0] seed);
    logic [OUT_DIM-1:0] f;
    f = '0;
    for (int s = 0; s < ND; s++)
      for (int b = 0; b < COL_W / 16; b++)
        f[s*COL_W + b*16 +: 16] = {seed, 8'(s)};
    return f;
  endfunction

  function automatic logic [COL_W-1:0] col(input logic [OUT_DIM-1:0] f, input int s);
    return f[s*COL_W +: COL_W];
  endfunction

  task automatic check(input string nm, input logic [COL_W-1:0] act, input logic [COL_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock; any handshake completing on this edge is checked against the expected frame
  task automatic step();
    if (mon_en && led_valid && led_ready)
      check($sformatf("accepted column slot %0d", slot_idx), led_data, col(exp_frame, int'(slot_idx)));
    @(posedge clock);
    #1;
    if (frame_ack) ack_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic hall_rise();
    hall = 1'b1;
    step();
    hall = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " locked"}, locked, 0);
    check({tag, " led_valid"}, led_valid, 0);
    check({tag, " slot_idx"}, slot_idx, 0);
    check({tag, " underrun"}, underrun, 0);
    check({tag, " overspeed"}, overspeed, 0);
    check({tag, " frame_ack"}, frame_ack, 0);
    check({tag, " led_data"}, led_data, 0);
  endtask

  initial begin
    // gap cycles to the sample point; a rise is placed on the last of them
    tbl[0]  = '{1,    1, 0,  0, 0};
    tbl[1]  = '{1599, 0, 0,  0, 0};
    tbl[2]  = '{1,    1, 0,  1, 1};
    tbl[3]  = '{1,    0, 0,  0, 1};
    tbl[4]  = '{99,   0, 1,  1, 1};
    tbl[5]  = '{1,    0, 1,  0, 1};
    tbl[6]  = '{699,  0, 8,  1, 1};
    tbl[7]  = '{700,  0, 15, 1, 1};
    tbl[8]  = '{100,  0, 15, 0, 1};
    tbl[9]  = '{50,   0, 15, 0, 1};
    tbl[10] = '{350,  1, 0,  1, 1};
    tbl[11] = '{124,  0, 0,  0, 1};
    tbl[12] = '{1,    0, 1,  1, 1};
    tbl[13] = '{125,  0, 2,  1, 1};
    tbl[14] = '{950,  1, 0,  1, 1};
    tbl[15] = '{75,   0, 1,  1, 1};

    run(3);
    check_zero("reset");
    resetn = 1'b1;
    step();

    frame_in = make_frame(8'h5C);
    frame_valid = 1'b1;
    step();
    check("initial frame ack", frame_ack, 1);
    frame_valid = 1'b0;
    step();
    exp_frame = make_frame(8'h5C);
    mon_en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].rise) begin
        run(tbl[i].gap - 1);
        hall_rise();
      end else begin
        run(tbl[i].gap);
      end
      check($sformatf("vec%0d slot_idx", i), slot_idx, tbl[i].slot);
      check($sformatf("vec%0d led_valid", i), led_valid, tbl[i].vld);
      check($sformatf("vec%0d locked", i), locked, tbl[i].lck);
      if (tbl[i].vld)
        check($sformatf("vec%0d led_data", i), led_data, col(exp_frame, tbl[i].slot));
    end
    check("no underrun with ready high", underrun, 0);
    check("no overspeed at valid periods", overspeed, 0);

    // Driver stalls for the whole of slot 3
    run(1124);
    hall_rise();
    run(224);
    led_ready = 1'b0;
    step();
    check("stall slot3 valid", led_valid, 1);
    check("stall slot3 data", led_data, col(exp_frame, 3));
    run(35);
    check("stall held valid", led_valid, 1);
    check("stall held data", led_data, col(exp_frame, 3));
    check("stall underrun not yet", underrun, 0);
    run(40);
    check("stall slot4 idx", slot_idx, 4);
    check("stall slot4 valid", led_valid, 1);
    check("stall slot4 data", led_data, col(exp_frame, 4));
    check("stall underrun set", underrun, 1);
    led_ready = 1'b1;

    // Frame A then B offered mid-revolution
    fa = make_frame(8'hA1);
    fb = make_frame(8'hB2);
    run(100);
    frame_in = fa;
    frame_valid = 1'b1;
    step();
    check("frame A ack", frame_ack, 1);
    ack_base = ack_cnt;
    frame_in = fb;
    step();
    check("frame B no ack", frame_ack, 0);
    run(797);
    check("frame B waits", ack_cnt, ack_base);
    hall_rise();
    exp_frame = fa;
    check("frame B ack at rise", frame_ack, 1);
    check("frame A slot0 idx", slot_idx, 0);
    check("frame A slot0 valid", led_valid, 1);
    check("frame A slot0 data", led_data, col(fa, 0));
    frame_valid = 1'b0;
    run(1199);
    hall_rise();
    exp_frame = fb;
    check("frame B slot0 data", led_data, col(fb, 0));
    check("single ack for B", ack_cnt, ack_base + 1);

    // Reset during slot 7
    run(550);
    check("pre-reset slot", slot_idx, 7);
    check("pre-reset locked", locked, 1);
    resetn = 1'b0;
    step();
    check_zero("mid-run reset");
    resetn = 1'b1;
    exp_frame = '0;

    // Overspeed, then hall timeout back to idle
    hall_rise();
    check("one rise not locked", locked, 0);
    run(99);
    hall_rise();
    check("fast rev overspeed", overspeed, 1);
    check("fast rev not locked", locked, 0);
    run(4200);
    check("timeout not locked", locked, 0);
    hall_rise();
    check("idle needs two rises", locked, 0);
    run(1599);
    hall_rise();
    check("relock locked", locked, 1);
    check("relock slot", slot_idx, 0);
    check("relock valid", led_valid, 1);
    check("relock cleared frame", led_data, 0);
    check("relock underrun cleared", underrun, 0);
    check("overspeed sticky", overspeed, 1);
    run(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
